// File: rtl/buffer_reader_if.sv
// buffer_reader_if: bundle between the width-conversion buffer read side,
// the buffer_reader, and the downstream word sink.
//   empty     buffer has no full J-word group
//   par_in    J words at the buffer read pointer (word i = par_in[i*WIDTH +: WIDTH])
//   rd_en     read-pointer load strobe back to the buffer
//   ser_out   serial word, ser_valid/ser_ready handshake, ser_last on final word
//   busy      reader holds a group
// master = reader side, slave = buffer/sink side.
interface buffer_reader_if #(
  parameter int WIDTH = 8,
  parameter int J     = 4
);
  logic                 empty;
  logic [WIDTH*J-1:0]   par_in;
  logic                 rd_en;
  logic [WIDTH-1:0]     ser_out;
  logic                 ser_valid;
  logic                 ser_ready;
  logic                 ser_last;
  logic                 busy;

  modport master (
    input  empty, par_in, ser_ready,
    output rd_en, ser_out, ser_valid, ser_last, busy
  );

  modport slave (
    output empty, par_in, ser_ready,
    input  rd_en, ser_out, ser_valid, ser_last, busy
  );
endinterface

// File: rtl/buffer_reader.sv
// buffer_reader: pulls one J-word group from the width-conversion buffer and
// serialises it onto a WIDTH-bit valid/ready stream.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  buffer_reader_if.master (empty, par_in, rd_en, ser_* stream, busy)
// Build option: READER_MSB_FIRST_EN sends word J-1 first down to word 0;
// default sends word 0 first. Handshake and rd_en timing are identical.
module buffer_reader #(
  parameter  int WIDTH = 8,
  parameter  int J     = 4,
  localparam int CBIT  = $clog2(J)
) (
  input  logic             clk,
  input  logic             rst,
  buffer_reader_if.master  bus
);
  typedef enum logic {IDLE, SEND} state_t;

  localparam logic [CBIT-1:0] IDX_LAST = CBIT'(J - 1);

  state_t                      state_q, state_d;
  logic [CBIT-1:0]             idx_q, idx_d;
  logic [J-1:0][WIDTH-1:0]     hold_q;
  logic [CBIT-1:0]             sel;
  logic                        load;
  logic                        hs;
  logic                        at_last;

  assign at_last = (idx_q == IDX_LAST);
  assign hs      = (state_q == SEND) & bus.ser_ready;

`ifdef READER_MSB_FIRST_EN
  assign sel = IDX_LAST - idx_q;
`else
  assign sel = idx_q;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!bus.empty) begin
          load    = 1'b1;
          state_d = SEND;
          idx_d   = '0;
        end
      end
      SEND: begin
        if (hs) begin
          // idx wraps J-1 -> 0 naturally, which is also the reload index.
          idx_d = idx_q + CBIT'(1);
          if (at_last) begin
            if (!bus.empty) load    = 1'b1;
            else            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (load) hold_q <= bus.par_in;
    end
  end

  // Pointer advance must never fire while reset is held.
  assign bus.rd_en     = load & ~rst;
  assign bus.ser_valid = (state_q == SEND);
  assign bus.busy      = (state_q == SEND);
  assign bus.ser_last  = (state_q == SEND) & at_last;
  assign bus.ser_out   = (state_q == SEND) ? hold_q[sel] : '0;
endmodule

// File: tb/tb_buffer_reader.sv
module tb_buffer_reader;
  localparam int W = 8;
  localparam int J = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  buffer_reader_if #(.WIDTH(W), .J(J)) bus ();
  buffer_reader #(.WIDTH(W), .J(J)) dut (.clk(clk), .rst(rst), .bus(bus.master));

  int n_cmp = 0;
  int n_bad = 0;

  // Word sent at position k of a group, following the build's serial order.
  function automatic logic [W-1:0] wsel(input logic [W*J-1:0] p, input int k);
`ifdef READER_MSB_FIRST_EN
    return p[(J-1-k)*W +: W];
`else
    return p[k*W +: W];
`endif
  endfunction

  // {rd_en, ser_valid, ser_last, busy, ser_out}
  function automatic logic [W+3:0] dut_obs();
    return {bus.rd_en, bus.ser_valid, bus.ser_last, bus.busy, bus.ser_out};
  endfunction

  task automatic cmp(input string nm, input logic [W+3:0] act, input logic [W+3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t got rd/v/last/busy/out=%b/%b/%b/%b/%h want %b/%b/%b/%b/%h",
               nm, $time, act[W+3], act[W+2], act[W+1], act[W], act[W-1:0],
               exp[W+3], exp[W+2], exp[W+1], exp[W], exp[W-1:0]);
    end
  endtask

  // Reference model: queue of words still owed to the sink.
  logic [W-1:0] wq[$];

  task automatic step(input logic r, input logic e, input logic [W*J-1:0] p,
                      input logic rdy, input string nm);
    logic          ev, el, erd;
    logic [W-1:0]  eo;
    rst = r; bus.empty = e; bus.par_in = p; bus.ser_ready = rdy;
    @(negedge clk);
    ev  = !r && (wq.size() > 0);
    eo  = ev ? wq[0] : '0;
    el  = ev && (wq.size() == 1);
    erd = !r && !e && ((wq.size() == 0) || (rdy && wq.size() == 1));
    cmp(nm, dut_obs(), {erd, ev, el, ev, eo});
    if (r) wq.delete();
    else begin
      if (ev && rdy) void'(wq.pop_front());
      if (erd) for (int k = 0; k < J; k++) wq.push_back(wsel(p, k));
    end
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic           rst;
    logic           empty;
    logic [W*J-1:0] par;
    logic           ready;
    int             k;      // position within group of the expected word
    logic           rd;
    logic           v;
    logic           last;
  } vec_t;

  localparam logic [W*J-1:0] G1 = 32'h44332211;
  localparam logic [W*J-1:0] G2 = 32'h88776655;
  localparam logic [W*J-1:0] G3 = 32'hDDCCBBAA;

  vec_t tbl[16];

  initial begin
    logic [W-1:0] eo;
    // reset with data waiting, then single group with free-running sink
    tbl[0]  = '{1'b1, 1'b0, G1, 1'b1, 0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, G1, 1'b1, 0, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, G1, 1'b1, 0, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, G1, 1'b1, 1, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, G1, 1'b1, 2, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, G1, 1'b1, 3, 1'b0, 1'b1, 1'b1};
    tbl[6]  = '{1'b0, 1'b1, G1, 1'b1, 0, 1'b0, 1'b0, 1'b0};
    // backpressure: ready 1,0,0,1,1,0,1 over the group
    tbl[7]  = '{1'b0, 1'b0, G1, 1'b1, 0, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, G1, 1'b1, 0, 1'b0, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, G1, 1'b0, 1, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 1'b1, G1, 1'b0, 1, 1'b0, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 1'b1, G1, 1'b1, 1, 1'b0, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 1'b1, G1, 1'b1, 2, 1'b0, 1'b1, 1'b0};
    tbl[13] = '{1'b0, 1'b1, G1, 1'b0, 3, 1'b0, 1'b1, 1'b1};
    tbl[14] = '{1'b0, 1'b1, G1, 1'b1, 3, 1'b0, 1'b1, 1'b1};
    tbl[15] = '{1'b0, 1'b1, G1, 1'b1, 0, 1'b0, 1'b0, 1'b0};

    rst = 1'b1; bus.empty = 1'b1; bus.par_in = '0; bus.ser_ready = 1'b0;
    @(posedge clk); #1;

    foreach (tbl[i]) begin
      rst = tbl[i].rst; bus.empty = tbl[i].empty;
      bus.par_in = tbl[i].par; bus.ser_ready = tbl[i].ready;
      @(negedge clk);
      eo = tbl[i].v ? wsel(tbl[i].par, tbl[i].k) : '0;
      cmp($sformatf("vec%0d", i), dut_obs(), {tbl[i].rd, tbl[i].v, tbl[i].last, tbl[i].v, eo});
      @(posedge clk); #1;
    end

    // back-to-back groups, no bubble
    wq.delete();
    for (int c = 0; c < 4; c++) step(1'b0, 1'b0, G1, 1'b1, "b2b_a");
    step(1'b0, 1'b0, G2, 1'b1, "b2b_b");
    for (int c = 0; c < 5; c++) step(1'b0, 1'b1, G2, 1'b1, "b2b_c");

    // reset mid-group: group lost, stays idle after release with empty
    step(1'b0, 1'b0, G3, 1'b1, "mrst_ld");
    step(1'b0, 1'b1, G3, 1'b1, "mrst_w0");
    step(1'b0, 1'b1, G3, 1'b1, "mrst_w1");
    step(1'b1, 1'b1, G3, 1'b1, "mrst_rst");
    for (int c = 0; c < 3; c++) step(1'b0, 1'b1, G3, 1'b1, "mrst_idle");

    // constrained random against the queue model
    for (int c = 0; c < 600; c++) begin
      step(($urandom_range(0, 79) == 0), ($urandom_range(0, 1) == 0),
           $urandom(), ($urandom_range(0, 9) < 7), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
